// File: rtl/mem_bus_bridge_if.sv
// External memory bus between the bridge (master) and the bus target (slave).
// A transfer is a held request answered by a single-cycle acknowledge;
// read data is valid only in the acknowledge cycle.
interface mem_bus_bridge_if;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;

    modport master (
        output bus_req_o,
        output bus_we_o,
        output bus_addr_o,
        output bus_sel_o,
        output bus_wdata_o,
        input  bus_rdata_i,
        input  bus_ack_i
    );

    modport slave (
        input  bus_req_o,
        input  bus_we_o,
        input  bus_addr_o,
        input  bus_sel_o,
        input  bus_wdata_o,
        output bus_rdata_i,
        output bus_ack_i
    );
endinterface

// File: rtl/mem_bus_bridge.sv
// Bridges the core's single-cycle MEM-stage data port onto a multi-cycle
// req/ack bus. The pipeline is stalled while a transfer is outstanding, and
// a transfer that is not acknowledged within TIMEOUT_CYCLES is abandoned
// and flagged on a sticky error output.
module mem_bus_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_ce_i,
    input  logic            cpu_we_i,
    input  logic [31:0]     cpu_addr_i,
    input  logic [3:0]      cpu_sel_i,
    input  logic [31:0]     cpu_data_i,
    output logic [31:0]     cpu_data_o,
    output logic            stallreq_o,
    output logic            err_o,
    mem_bus_bridge_if.master bus
);

    // Counter is wide enough to hold TIMEOUT_CYCLES; the abort fires at
    // TIMEOUT_CYCLES-1 so the counter can never wrap.
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;

    logic              we_r;
    logic [31:2]       addr_r;
    logic [3:0]        sel_r;
    logic [31:0]       wdata_r;
    logic [31:0]       rdata_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              err_r;

    logic              ack_s;
    logic              timeout_s;
    logic              bus_req_s;
    logic              stall_s;

    // Acknowledge only counts while a transfer is outstanding; an ack in the
    // same cycle as the timeout wins over the abort.
    assign ack_s     = (state_r == ST_BUSY) && bus.bus_ack_i;
    assign timeout_s = (state_r == ST_BUSY) && !bus.bus_ack_i && (cnt_r == CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cpu_ce_i) begin
                    state_next_s = ST_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (ack_s || timeout_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                // The finishing access still has ce high here; it is not re-issued.
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output decode: request while busy, stall from the new access until completion
    always_comb begin
        bus_req_s = 1'b0;
        stall_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                bus_req_s = 1'b0;
                stall_s   = cpu_ce_i;
            end
            ST_BUSY: begin
                bus_req_s = 1'b1;
                stall_s   = 1'b1;
            end
            ST_DONE: begin
                bus_req_s = 1'b0;
                stall_s   = 1'b0;
            end
            default: begin
                bus_req_s = 1'b0;
                stall_s   = 1'b0;
            end
        endcase
    end

    // Request capture, wait counter, read-data and sticky-error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            we_r    <= 1'b0;
            addr_r  <= 30'h0;
            sel_r   <= 4'h0;
            wdata_r <= 32'h0;
            rdata_r <= 32'h0;
            cnt_r   <= CNT_ZERO;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cpu_ce_i) begin
                        we_r    <= cpu_we_i;
                        addr_r  <= cpu_addr_i[31:2];
                        sel_r   <= cpu_sel_i;
                        wdata_r <= cpu_data_i;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        cnt_r   <= cnt_r;
                    end
                end
                ST_BUSY: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if (ack_s) begin
                        if (!we_r) begin
                            rdata_r <= bus.bus_rdata_i;
                        end else begin
                            rdata_r <= rdata_r;
                        end
                    end else if (timeout_s) begin
                        err_r   <= 1'b1;
                        rdata_r <= 32'h0;
                    end else begin
                        rdata_r <= rdata_r;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Bus fields come straight from the capture registers so they stay
    // stable for the whole transfer; the address is forced word-aligned.
    assign bus.bus_req_o   = bus_req_s;
    assign bus.bus_we_o    = we_r;
    assign bus.bus_addr_o  = {addr_r, 2'b00};
    assign bus.bus_sel_o   = sel_r;
    assign bus.bus_wdata_o = wdata_r;

    assign stallreq_o = stall_s;
    assign cpu_data_o = rdata_r;
    assign err_o      = err_r;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Self-checking bench for mem_bus_bridge. The bench plays the bus target;
// expected read data is queued when an access is issued and compared when
// the bridge reaches its completion cycle.
module tb_mem_bus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ce;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_sel;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stallreq;
    logic        err;

    mem_bus_bridge_if bif ();

    mem_bus_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_ce_i   (cpu_ce),
        .cpu_we_i   (cpu_we),
        .cpu_addr_i (cpu_addr),
        .cpu_sel_i  (cpu_sel),
        .cpu_data_i (cpu_wdata),
        .cpu_data_o (cpu_rdata),
        .stallreq_o (stallreq),
        .err_o      (err),
        .bus        (bif.master)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    // Request-edge monitor: counts transactions and the req-low gap before each one
    int   req_rises = 0;
    int   low_run   = 0;
    int   last_gap  = 0;
    logic req_prev  = 1'b0;

    always @(negedge clk) begin
        if (bif.bus_req_o === 1'b1 && req_prev === 1'b0) begin
            req_rises <= req_rises + 1;
            last_gap  <= low_run;
        end
        if (bif.bus_req_o === 1'b1) begin
            low_run <= 0;
        end else begin
            low_run <= low_run + 1;
        end
        req_prev <= bif.bus_req_o;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete access starting in an IDLE cycle. The bus target acks in
    // busy cycle number 'waits' (0 = first busy cycle). Returns the number of
    // cycles with req high and with stall high.
    task automatic run_access(input logic t_we, input logic [31:0] t_addr,
                              input logic [3:0] t_sel, input logic [31:0] t_wd,
                              input logic [31:0] t_rd, input int waits,
                              input logic [31:0] exp_addr, input logic [31:0] exp_data,
                              input logic exp_err, input bit keep_ce,
                              output int busy_n, output int stall_n);
        bit          done;
        logic [31:0] exp_v;
        cpu_ce    = 1'b1;
        cpu_we    = t_we;
        cpu_addr  = t_addr;
        cpu_sel   = t_sel;
        cpu_wdata = t_wd;
        bif.bus_ack_i = 1'b0;
        exp_q.push_back(exp_data);
        busy_n  = 0;
        stall_n = 0;
        done    = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bif.bus_req_o !== 1'b0 || stallreq !== 1'b1) begin
            n_err++;
            $display("FAIL idle_cycle addr=%h: req=%b stall=%b, required req=0 stall=1",
                     t_addr, bif.bus_req_o, stallreq);
        end
        if (stallreq === 1'b1) stall_n++;
        for (int c = 0; c < 40 && !done; c++) begin
            step();
            bif.bus_ack_i   = (c == waits);
            bif.bus_rdata_i = (c == waits) ? t_rd : ~t_rd;
            @(negedge clk);
            if (bif.bus_req_o === 1'b1) begin
                busy_n++;
                if (stallreq === 1'b1) stall_n++;
                n_cmp++;
                if ({bif.bus_we_o, bif.bus_addr_o, bif.bus_sel_o, bif.bus_wdata_o}
                    !== {t_we, exp_addr, t_sel, t_wd}) begin
                    n_err++;
                    $display("FAIL bus_fields cyc=%0d: we=%b addr=%h sel=%h wd=%h, required we=%b addr=%h sel=%h wd=%h",
                             c, bif.bus_we_o, bif.bus_addr_o, bif.bus_sel_o, bif.bus_wdata_o,
                             t_we, exp_addr, t_sel, t_wd);
                end
            end else begin
                done = 1'b1;
                n_cmp++;
                if (stallreq !== 1'b0) begin
                    n_err++;
                    $display("FAIL done_stall addr=%h: stall=%b, required 0", t_addr, stallreq);
                end
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL done_data addr=%h: scoreboard empty, got %h", t_addr, cpu_rdata);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (cpu_rdata !== exp_v) begin
                        n_err++;
                        $display("FAIL done_data addr=%h: got %h, required %h", t_addr, cpu_rdata, exp_v);
                    end
                end
                n_cmp++;
                if (err !== exp_err) begin
                    n_err++;
                    $display("FAIL done_err addr=%h: got %b, required %b", t_addr, err, exp_err);
                end
            end
        end
        if (!done) begin
            n_err++;
            $display("FAIL access_bound addr=%h: no completion within 40 cycles", t_addr);
        end
        step();
        bif.bus_ack_i = 1'b0;
        if (!keep_ce) cpu_ce = 1'b0;
    endtask

    task automatic check_lat(input string name, input int busy_n, input int stall_n,
                             input int exp_busy, input int exp_stall);
        n_cmp++;
        if (busy_n != exp_busy || stall_n != exp_stall) begin
            n_err++;
            $display("FAIL %s_latency: req_cycles=%0d stall_cycles=%0d, required %0d / %0d",
                     name, busy_n, stall_n, exp_busy, exp_stall);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cpu_ce = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_sel = 4'h0; cpu_wdata = 32'h0;
        bif.bus_ack_i = 1'b0; bif.bus_rdata_i = 32'h0;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bif.bus_req_o, stallreq, err, cpu_rdata} !== {1'b0, 1'b0, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL reset_outputs: req=%b stall=%b err=%b data=%h, required 0 0 0 0",
                     bif.bus_req_o, stallreq, err, cpu_rdata);
        end
        n_cmp++;
        if ({bif.bus_we_o, bif.bus_addr_o, bif.bus_sel_o, bif.bus_wdata_o} !== 69'h0) begin
            n_err++;
            $display("FAIL reset_bus: we=%b addr=%h sel=%h wd=%h, required all 0",
                     bif.bus_we_o, bif.bus_addr_o, bif.bus_sel_o, bif.bus_wdata_o);
        end
        step();
    endtask

    task automatic test_read();
        int b, s;
        run_access(1'b0, 32'h0000_0100, 4'hF, 32'h0, 32'hDEAD_BEEF, 0,
                   32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 1'b0, b, s);
        check_lat("read", b, s, 1, 2);
    endtask

    // Ack lands in the same cycle the 4-cycle timeout would fire: ack must win.
    task automatic test_write();
        int b, s;
        run_access(1'b1, 32'h0000_0203, 4'b1000, 32'h1234_5678, 32'hCAFE_F00D, 3,
                   32'h0000_0200, 32'hDEAD_BEEF, 1'b0, 1'b0, b, s);
        check_lat("write", b, s, 4, 5);
    endtask

    task automatic test_spurious_ack();
        int rises0;
        rises0 = req_rises;
        cpu_ce = 1'b0;
        bif.bus_ack_i   = 1'b1;
        bif.bus_rdata_i = 32'h55AA_55AA;
        @(negedge clk);
        n_cmp++;
        if ({bif.bus_req_o, stallreq, cpu_rdata} !== {1'b0, 1'b0, 32'hDEAD_BEEF}) begin
            n_err++;
            $display("FAIL spurious_ack: req=%b stall=%b data=%h, required 0 0 deadbeef",
                     bif.bus_req_o, stallreq, cpu_rdata);
        end
        step();
        bif.bus_ack_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bif.bus_req_o, cpu_rdata, err} !== {1'b0, 32'hDEAD_BEEF, 1'b0} || req_rises != rises0) begin
            n_err++;
            $display("FAIL spurious_after: req=%b data=%h err=%b new_reqs=%0d, required 0 deadbeef 0 0",
                     bif.bus_req_o, cpu_rdata, err, req_rises - rises0);
        end
        step();
    endtask

    task automatic test_timeout();
        int b, s;
        run_access(1'b0, 32'h0000_0300, 4'hF, 32'h0, 32'h1111_1111, 99,
                   32'h0000_0300, 32'h0, 1'b1, 1'b0, b, s);
        check_lat("timeout", b, s, 4, 5);
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b1 || bif.bus_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_sticky: err=%b req=%b, required 1 0", err, bif.bus_req_o);
        end
        step();
        run_access(1'b0, 32'h0000_0304, 4'hF, 32'h0, 32'hA5A5_A5A5, 1,
                   32'h0000_0304, 32'hA5A5_A5A5, 1'b1, 1'b0, b, s);
        check_lat("post_timeout_read", b, s, 2, 3);
    endtask

    // DONE then IDLE separate the two requests, so req is low for two cycles.
    task automatic test_back_to_back();
        int b, s, rises0;
        rises0 = req_rises;
        run_access(1'b0, 32'h0000_0010, 4'hF, 32'h0, 32'h0101_0101, 0,
                   32'h0000_0010, 32'h0101_0101, 1'b1, 1'b1, b, s);
        check_lat("b2b_first", b, s, 1, 2);
        run_access(1'b0, 32'h0000_0014, 4'hF, 32'h0, 32'h0202_0202, 0,
                   32'h0000_0014, 32'h0202_0202, 1'b1, 1'b0, b, s);
        check_lat("b2b_second", b, s, 1, 2);
        n_cmp++;
        if (req_rises - rises0 != 2 || last_gap != 2) begin
            n_err++;
            $display("FAIL b2b_gap: transactions=%0d gap=%0d, required 2 and 2",
                     req_rises - rises0, last_gap);
        end
    endtask

    task automatic test_reset_mid_busy();
        int b, s;
        cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0040; cpu_sel = 4'hF;
        step();
        bif.bus_ack_i = 1'b0;
        step();
        rst = 1'b1;
        cpu_ce = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bif.bus_req_o !== 1'b1) begin
            n_err++;
            $display("FAIL rst_busy_req: req=%b in second busy cycle, required 1", bif.bus_req_o);
        end
        step();
        rst = 1'b0;
        bif.bus_ack_i   = 1'b1;
        bif.bus_rdata_i = 32'h7777_7777;
        @(negedge clk);
        n_cmp++;
        if ({bif.bus_req_o, stallreq, err, cpu_rdata} !== {1'b0, 1'b0, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL rst_busy_after: req=%b stall=%b err=%b data=%h, required 0 0 0 0",
                     bif.bus_req_o, stallreq, err, cpu_rdata);
        end
        cpu_ce = 1'b1;
        #1;
        n_cmp++;
        if (stallreq !== 1'b1) begin
            n_err++;
            $display("FAIL rst_idle_stall: stall=%b with ce=1 in IDLE, required 1", stallreq);
        end
        cpu_ce = 1'b0;
        step();
        bif.bus_ack_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bif.bus_req_o, cpu_rdata} !== {1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL rst_late_ack: req=%b data=%h, required 0 0", bif.bus_req_o, cpu_rdata);
        end
        step();
        run_access(1'b0, 32'h0000_0044, 4'hF, 32'h0, 32'h4444_0044, 0,
                   32'h0000_0044, 32'h4444_0044, 1'b0, 1'b0, b, s);
        check_lat("post_reset_read", b, s, 1, 2);
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_spurious_ack();
        test_timeout();
        test_back_to_back();
        test_reset_mid_busy();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: %0d entries, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
